alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
- Sequencer that drives one external 4-bit ALU slice (mode/select/A/B/carry-in in; F/carry-out/compare out) to perform a full-width operation nibble-serially, LSB nibble first.
- Carry-out of each nibble is registered and fed back as carry-in of the next nibble.
- Sits between a valid/ready request source and the ALU slice instance, and returns a full-width result on a valid/ready response channel.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operation (2..16).
- WIDTH, 4*NIBBLES, operand/result width. Derived; must not be overridden.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- mode_i  in  1  ALU mode control for the whole operation
- select_i  in  4  ALU function select for the whole operation
- op_a_i  in  WIDTH  operand A
- op_b_i  in  WIDTH  operand B
- carry_in_i  in  1  carry into nibble 0; polarity passed through untouched
- alu_mode_control_o  out  1  to slice mode_control_i
- alu_select_input_o  out  4  to slice select_input_i
- alu_operand_a_o  out  4  current A nibble
- alu_operand_b_o  out  4  current B nibble
- alu_carry_input_o  out  1  current carry-in
- alu_function_output_i  in  4  slice F output (combinational from the alu_* outputs)
- alu_carry_output_i  in  1  slice carry-out
- alu_cmp_output_i  in  1  slice compare output
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- result_o  out  WIDTH  assembled F nibbles
- carry_o  out  1  carry-out of the last nibble
- eq_o  out  1  AND of cmp over all nibbles

Behaviour:
- Reset and clock are decided: one clock clk_i; reset rst_n_i is synchronous, active-low. Reset takes effect on the clock edge it is sampled low.
- Reset values:
  - state IDLE, nibble counter 0
  - req_ready_o=1, rsp_valid_o=0
  - result_o=0, carry_o=0, eq_o=0
  - all alu_* outputs 0
- FSM states:
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o at edge E0: latch mode, select, A, B into registers; carry register <= carry_in_i; eq register <= 1; counter <= 0; go to RUN.
  - RUN: req_ready_o=0.
    - alu_* outputs are driven from registers: nibble index = counter, carry = carry register. They are glitch-free and stable for the whole cycle.
    - At each edge: result nibble[counter] <= alu_function_output_i; carry register <= alu_carry_output_i; eq register <= eq & alu_cmp_output_i; counter++.
    - After the edge capturing nibble NIBBLES-1 (E_NIBBLES), go to DONE.
  - DONE: rsp_valid_o=1; result_o/carry_o/eq_o held stable; alu_* outputs driven to 0. On rsp_valid_o&&rsp_ready_i, go to IDLE.
- Latency:
  - Request accepted at E0; nibble k presented in cycle (E_k, E_k+1).
  - rsp_valid_o is high from E_NIBBLES, i.e. NIBBLES cycles after acceptance.
- No overlap: req_ready_o is low in RUN and DONE.
  - A request offered in the cycle a response is consumed is accepted one cycle later (one-cycle bubble).
- req_valid_i while not ready: ignored; no state change.
- Operand inputs are sampled only at acceptance. Later changes have no effect.
- mode=1 (logic): carry is still chained and reported. The slice ignores it; the sequencer does not special-case it.
- Counter wraps only via the DONE→IDLE path; it never exceeds NIBBLES-1.
- Reset mid-RUN or mid-DONE: on the next edge with rst_n_i=0, return to IDLE with reset values. The in-flight result is discarded and no response is produced.
- The combinational path from alu_* outputs through the slice back to the *_i inputs must close in one cycle. No other combinational in→out paths are permitted.

Decomposition:
- Shared package/include alu_seq_pkg:
  - NIB_W=4
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
- No sub-module. The ALU slice is instantiated by the parent, not inside this block.
- Operand and result nibble access is indexed by counter; no separate shifter module.

Test Plan:
- Bench uses stub slice: F=A+B+cin (4-bit), cout=bit4, cmp=(F==4'hF). NIBBLES=4 throughout.
1. a=16'h0FFF, b=16'h0001, cin=0:
   - slice sees A/B nibbles F/1, F/0, F/0, 0/0 with carry-in 0,1,1,1
   - result_o=16'h1000, carry_o=0
   - rsp_valid_o rises exactly 4 cycles after acceptance
2. a=16'hFFFF, b=16'h0001, cin=0 -> result_o=16'h0000, carry_o=1, eq_o=0.
3. a=16'hFFFF, b=16'h0000, cin=0 -> eq_o=1. Then a=16'hFFFE, b=16'h0000 -> eq_o=0.
4. Backpressure: hold rsp_ready_i=0 for 3 cycles while req_valid_i=1 with new operands:
   - result_o stable, req_ready_o=0, new request not accepted
   - after handshake, new request accepted the next cycle
5. Reset: rst_n_i=0 for one cycle during RUN at nibble 2:
   - next cycle IDLE, req_ready_o=1, rsp_valid_o=0, alu_* outputs=0
   - no response ever appears for the aborted request
6. Passthrough: mode_i=1, select_i=4'b1011, with mode_i/select_i changed after acceptance:
   - alu_mode_control_o=1 and alu_select_input_o=4'b1011 held for all 4 RUN cycles
   - both are 0 in IDLE/DONE

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble_seq.sv
// Drives an external 4-bit ALU slice nibble-serially (LSB first), chaining carry
// between nibbles and returning the assembled result on a valid/ready channel.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH   = NIB_W * NIBBLES
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             mode_i,
  input  logic [3:0]       select_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             carry_in_i,
  output logic             alu_mode_control_o,
  output logic [3:0]       alu_select_input_o,
  output logic [3:0]       alu_operand_a_o,
  output logic [3:0]       alu_operand_b_o,
  output logic             alu_carry_input_o,
  input  logic [3:0]       alu_function_output_i,
  input  logic             alu_carry_output_i,
  input  logic             alu_cmp_output_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             eq_o
);

  localparam int unsigned CNT_W = $clog2(NIBBLES);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             eq_q;
  logic             ready_q;
  logic             valid_q;
  logic             alu_mode_q;
  logic [3:0]       alu_sel_q;
  logic [3:0]       alu_a_q;
  logic [3:0]       alu_b_q;
  logic             alu_cin_q;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    last    = (cnt == CNT_W'(NIBBLES - 1));
  end

  // Slice-facing signals are registered one nibble ahead so the slice sees
  // flop outputs only; nibble 0 is loaded straight from the request inputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      alu_mode_q <= 1'b0;
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            a_q        <= op_a_i;
            b_q        <= op_b_i;
            carry_q    <= carry_in_i;
            eq_q       <= 1'b1;
            cnt        <= '0;
            ready_q    <= 1'b0;
            alu_mode_q <= mode_i;
            alu_sel_q  <= select_i;
            alu_a_q    <= op_a_i[NIB_W-1:0];
            alu_b_q    <= op_b_i[NIB_W-1:0];
            alu_cin_q  <= carry_in_i;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q[cnt*NIB_W +: NIB_W] <= alu_function_output_i;
          carry_q <= alu_carry_output_i;
          eq_q    <= eq_q & alu_cmp_output_i;
          if (last) begin
            valid_q    <= 1'b1;
            alu_mode_q <= 1'b0;
            alu_sel_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            state      <= ST_DONE;
          end else begin
            cnt       <= cnt_nxt;
            alu_a_q   <= a_q[cnt_nxt*NIB_W +: NIB_W];
            alu_b_q   <= b_q[cnt_nxt*NIB_W +: NIB_W];
            alu_cin_q <= alu_carry_output_i;
          end
        end
        ST_DONE: begin
          if (rsp_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            cnt     <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o        = ready_q;
  assign rsp_valid_o        = valid_q;
  assign result_o           = result_q;
  assign carry_o            = carry_q;
  assign eq_o               = eq_q;
  assign alu_mode_control_o = alu_mode_q;
  assign alu_select_input_o = alu_sel_q;
  assign alu_operand_a_o    = alu_a_q;
  assign alu_operand_b_o    = alu_b_q;
  assign alu_carry_input_o  = alu_cin_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with an adder stub standing in for the ALU slice.
module tb_alu_nibble_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned WIDTH   = 4 * NIBBLES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             mode = 1'b0;
  logic [3:0]       select = '0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             carry_in = 1'b0;
  logic             alu_mode;
  logic [3:0]       alu_sel;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             alu_cin;
  logic [3:0]       alu_f;
  logic             alu_cout;
  logic             alu_cmp;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             eq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [4:0] slice_sum;
  assign slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
  assign alu_f     = slice_sum[3:0];
  assign alu_cout  = slice_sum[4];
  assign alu_cmp   = (slice_sum[3:0] == 4'hF);

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .req_valid_i           (req_valid),
    .req_ready_o           (req_ready),
    .mode_i                (mode),
    .select_i              (select),
    .op_a_i                (op_a),
    .op_b_i                (op_b),
    .carry_in_i            (carry_in),
    .alu_mode_control_o    (alu_mode),
    .alu_select_input_o    (alu_sel),
    .alu_operand_a_o       (alu_a),
    .alu_operand_b_o       (alu_b),
    .alu_carry_input_o     (alu_cin),
    .alu_function_output_i (alu_f),
    .alu_carry_output_i    (alu_cout),
    .alu_cmp_output_i      (alu_cmp),
    .rsp_valid_o           (rsp_valid),
    .rsp_ready_i           (rsp_ready),
    .result_o              (result),
    .carry_o               (carry),
    .eq_o                  (eq)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Offers a request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic m, input logic [3:0] sel);
    op_a = a; op_b = b; carry_in = cin; mode = m; select = sel;
    req_valid = 1'b1;
    check("ready_before_send", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 20) check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    logic       exp_c [4];
    int         cyc;
    int         seen;

    exp_a = '{4'hF, 4'hF, 4'hF, 4'h0};
    exp_b = '{4'h1, 4'h0, 4'h0, 4'h0};
    exp_c = '{1'b0, 1'b1, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready",  32'(req_ready), 32'd1);
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_result", 32'(result),    32'd0);
    check("rst_carry",  32'(carry),     32'd0);
    check("rst_eq",     32'(eq),        32'd0);
    check("rst_alu",    32'({alu_mode, alu_sel, alu_a, alu_b, alu_cin}), 32'd0);

    // 1: carry ripple through three nibbles, exact latency
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      check("t1_nib_a",   32'(alu_a),     32'(exp_a[k]));
      check("t1_nib_b",   32'(alu_b),     32'(exp_b[k]));
      check("t1_nib_cin", 32'(alu_cin),   32'(exp_c[k]));
      check("t1_valid_lo", 32'(rsp_valid), 32'd0);
      check("t1_ready_lo", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    check("t1_valid_at4", 32'(rsp_valid), 32'd1);
    check("t1_result",    32'(result),    32'h1000);
    check("t1_carry",     32'(carry),     32'd0);
    check("t1_eq",        32'(eq),        32'd0);
    consume();

    // 2: full overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h0);
    wait_rsp(cyc);
    check("t2_latency", 32'(cyc),    32'd4);
    check("t2_result",  32'(result), 32'h0000);
    check("t2_carry",   32'(carry),  32'd1);
    check("t2_eq",      32'(eq),     32'd0);
    consume();

    // 3: all-ones compare, then one nibble off
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0, 4'h0);
    wait_rsp(cyc);
    check("t3a_result", 32'(result), 32'hFFFF);
    check("t3a_eq",     32'(eq),     32'd1);
    check("t3a_carry",  32'(carry),  32'd0);
    consume();
    send(16'hFFFE, 16'h0000, 1'b0, 1'b0, 4'h0);
    wait_rsp(cyc);
    check("t3b_result", 32'(result), 32'hFFFE);
    check("t3b_eq",     32'(eq),     32'd0);
    consume();

    // 4: response backpressure with a competing request
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 4'h0);
    wait_rsp(cyc);
    op_a = 16'h0F0F; op_b = 16'h0101; carry_in = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_result", 32'(result),    32'h2345);
      check("t4_hold_valid",  32'(rsp_valid), 32'd1);
      check("t4_hold_ready",  32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t4_bubble_ready", 32'(req_ready), 32'd1);
    check("t4_bubble_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("t4_accepted", 32'(req_ready), 32'd0);
    wait_rsp(cyc);
    check("t4_latency", 32'(cyc),    32'd4);
    check("t4_result",  32'(result), 32'h1010);
    check("t4_carry",   32'(carry),  32'd0);
    consume();

    // 5: reset while nibble 2 is on the slice
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    check("t5_nib2_a", 32'(alu_a), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_ready",  32'(req_ready), 32'd1);
    check("t5_valid",  32'(rsp_valid), 32'd0);
    check("t5_alu",    32'({alu_mode, alu_sel, alu_a, alu_b, alu_cin}), 32'd0);
    check("t5_result", 32'(result), 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t5_no_rsp", 32'(seen), 32'd0);

    // 6: mode/select passthrough, inputs changed after acceptance
    check("t6_idle_ctl", 32'({alu_mode, alu_sel}), 32'd0);
    send(16'h00FF, 16'h0F00, 1'b0, 1'b1, 4'b1011);
    mode = 1'b0; select = 4'b0000;
    op_a = 16'hAAAA; op_b = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      check("t6_mode", 32'(alu_mode), 32'd1);
      check("t6_sel",  32'(alu_sel),  32'hB);
      @(negedge clk);
    end
    check("t6_valid",    32'(rsp_valid), 32'd1);
    check("t6_done_ctl", 32'({alu_mode, alu_sel, alu_a, alu_b, alu_cin}), 32'd0);
    check("t6_result",   32'(result),    32'h0FFF);
    check("t6_eq",       32'(eq),        32'd0);
    consume();
    check("t6_idle_after", 32'({alu_mode, alu_sel}), 32'd0);
    check("t6_ready",      32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
